// File: rtl/tournament_pred_if.sv
// Pipeline-facing signals of the tournament branch predictor.
// The pipeline side drives through the master modport; the predictor uses the slave modport.
interface tournament_pred_if;
  logic        flushD;
  logic        stallD;
  logic [31:0] pcF;
  logic [31:0] pcM;
  logic        branchM;
  logic        actual_takeM;
  logic        branchD;
  logic        pred_takeD;
  logic        pred_srcD;
  logic        init_done;

  modport master (
    output flushD, stallD, pcF, pcM, branchM, actual_takeM, branchD,
    input  pred_takeD, pred_srcD, init_done
  );

  modport slave (
    input  flushD, stallD, pcF, pcM, branchM, actual_takeM, branchD,
    output pred_takeD, pred_srcD, init_done
  );
endinterface

// File: rtl/tournament_pred.sv
// Tournament branch predictor.
// Local two-level predictor (per-PC history -> local PHT) and a gshare global predictor
// (GHR ^ PC -> global PHT), arbitrated by a per-PC chooser. Lookup in F is registered
// into D. Training happens at M. An init sweep clears every table after reset, so the
// table arrays themselves carry no reset.
module tournament_pred #(
  parameter int BHT_DEPTH  = 10,
  parameter int LHR_W      = 6,
  parameter int PC_BITS_L  = 3,
  parameter int GHR_W      = 8,
  parameter int CPHT_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  tournament_pred_if.slave bus
);
  localparam int LPHT_AW = LHR_W + PC_BITS_L;
  localparam int BHT_N   = 1 << BHT_DEPTH;
  localparam int LPHT_N  = 1 << LPHT_AW;
  localparam int GPHT_N  = 1 << GHR_W;
  localparam int CPHT_N  = 1 << CPHT_DEPTH;
  localparam int MAX_AB  = (BHT_N > LPHT_N) ? BHT_N : LPHT_N;
  localparam int MAX_CD  = (GPHT_N > CPHT_N) ? GPHT_N : CPHT_N;
  localparam int INIT_N  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // One spare bit keeps the "entry exists in this table" compares non-constant.
  localparam int CNT_W   = $clog2(INIT_N) + 1;
  localparam int IDX_AB  = (BHT_DEPTH > PC_BITS_L) ? BHT_DEPTH : PC_BITS_L;
  localparam int IDX_CD  = (GHR_W > CPHT_DEPTH) ? GHR_W : CPHT_DEPTH;
  localparam int PC_MSB  = ((IDX_AB > IDX_CD) ? IDX_AB : IDX_CD) + 1;

  // 2-bit saturating counter: 00 SNT, 01 WNT, 10 WT, 11 ST; bit 1 is the prediction.
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;

  typedef enum logic {ST_INIT = 1'b0, ST_LIVE = 1'b1} state_t;

  function automatic ctr_t ctr_step(input ctr_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [LHR_W-1:0] r_bht  [BHT_N];
  ctr_t             r_lpht [LPHT_N];
  ctr_t             r_gpht [GPHT_N];
  ctr_t             r_cpht [CPHT_N];

  logic [GHR_W-1:0] r_ghr;
  logic [CNT_W-1:0] r_init_cnt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pred;
  logic             r_src;
  logic             w_live;

  // F-side lookup
  logic [BHT_DEPTH-1:0]  w_bht_idx_f;
  logic [LHR_W-1:0]      w_lhr_f;
  logic [LPHT_AW-1:0]    w_lpht_idx_f;
  logic [GHR_W-1:0]      w_gpht_idx_f;
  logic [CPHT_DEPTH-1:0] w_cpht_idx_f;
  logic                  w_pl_f;
  logic                  w_pg_f;
  logic                  w_sel_f;
  logic                  w_pred_f;

  // M-side recomputation for training
  logic [BHT_DEPTH-1:0]  w_bht_idx_m;
  logic [LHR_W-1:0]      w_lhr_m;
  logic [LPHT_AW-1:0]    w_lpht_idx_m;
  logic [GHR_W-1:0]      w_gpht_idx_m;
  logic [CPHT_DEPTH-1:0] w_cpht_idx_m;
  logic                  w_pl_m;
  logic                  w_pg_m;

  logic                  w_unused;

  assign w_live = (r_state == ST_LIVE);

  assign w_bht_idx_f  = bus.pcF[BHT_DEPTH+1:2];
  assign w_lhr_f      = r_bht[w_bht_idx_f];
  assign w_lpht_idx_f = {bus.pcF[PC_BITS_L+1:2], w_lhr_f};
  assign w_gpht_idx_f = bus.pcF[GHR_W+1:2] ^ r_ghr;
  assign w_cpht_idx_f = bus.pcF[CPHT_DEPTH+1:2];
  assign w_pl_f       = r_lpht[w_lpht_idx_f][1];
  assign w_pg_f       = r_gpht[w_gpht_idx_f][1];
  assign w_sel_f      = r_cpht[w_cpht_idx_f][1];
  assign w_pred_f     = w_sel_f ? w_pg_f : w_pl_f;

  assign w_bht_idx_m  = bus.pcM[BHT_DEPTH+1:2];
  assign w_lhr_m      = r_bht[w_bht_idx_m];
  assign w_lpht_idx_m = {bus.pcM[PC_BITS_L+1:2], w_lhr_m};
  assign w_gpht_idx_m = bus.pcM[GHR_W+1:2] ^ r_ghr;
  assign w_cpht_idx_m = bus.pcM[CPHT_DEPTH+1:2];
  assign w_pl_m       = r_lpht[w_lpht_idx_m][1];
  assign w_pg_m       = r_gpht[w_gpht_idx_m][1];

  assign bus.pred_takeD = bus.branchD & r_pred;
  assign bus.pred_srcD  = r_src;
  assign bus.init_done  = w_live;

  // PC bits that no table index uses.
  assign w_unused = ^{bus.pcF[31:PC_MSB+1], bus.pcF[1:0], bus.pcM[31:PC_MSB+1], bus.pcM[1:0]};

  // Init/live state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Leave the init sweep once the last entry has been written.
  // NOTE: the default assignment first means no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_cnt == CNT_W'(INIT_N - 1)) w_state_nxt = ST_LIVE;
  end

  // Init sweep address, restarted by every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_init_cnt <= '0;
    else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + CNT_W'(1);
  end

  // Global history: non-speculative, shifted only by resolved branches once live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_ghr <= '0;
    else if (w_live && bus.branchM) r_ghr <= {r_ghr[GHR_W-2:0], bus.actual_takeM};
  end

  // D-stage prediction register: flush beats stall; forced clear until live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred <= 1'b0;
      r_src  <= 1'b0;
    end else if (!w_live || bus.flushD) begin
      r_pred <= 1'b0;
      r_src  <= 1'b0;
    end else if (!bus.stallD) begin
      r_pred <= w_pred_f;
      r_src  <= w_sel_f;
    end
  end

  // Table writes: init sweep first, then training from resolved M-stage branches.
  // NOTE: the arrays have no reset; the init sweep clears them, keeping them RAM-mappable.
  always_ff @(posedge clk) begin
    if (!w_live) begin
      if (r_init_cnt < CNT_W'(BHT_N))  r_bht[r_init_cnt[BHT_DEPTH-1:0]]   <= '0;
      if (r_init_cnt < CNT_W'(LPHT_N)) r_lpht[r_init_cnt[LPHT_AW-1:0]]    <= CTR_WT;
      if (r_init_cnt < CNT_W'(GPHT_N)) r_gpht[r_init_cnt[GHR_W-1:0]]      <= CTR_WT;
      if (r_init_cnt < CNT_W'(CPHT_N)) r_cpht[r_init_cnt[CPHT_DEPTH-1:0]] <= CTR_WNT;
    end else if (bus.branchM) begin
      r_bht[w_bht_idx_m]   <= {w_lhr_m[LHR_W-2:0], bus.actual_takeM};
      r_lpht[w_lpht_idx_m] <= ctr_step(r_lpht[w_lpht_idx_m], bus.actual_takeM);
      r_gpht[w_gpht_idx_m] <= ctr_step(r_gpht[w_gpht_idx_m], bus.actual_takeM);
      if (w_pl_m != w_pg_m)
        r_cpht[w_cpht_idx_m] <= ctr_step(r_cpht[w_cpht_idx_m], w_pg_m == bus.actual_takeM);
    end
  end
endmodule

// File: tb/tb_tournament_pred.sv
// Self-checking bench for tournament_pred: init sweep, D-register control vectors,
// read-during-write, local loop learning, global correlation, and mid-run reset.
module tb_tournament_pred;
  localparam logic [31:0] PC_X    = 32'h0000_0018;
  localparam logic [31:0] PC_Y    = 32'h0000_001C;
  localparam logic [31:0] PC_LOOP = 32'h0040_0010;
  localparam logic [31:0] PC_A    = 32'h0000_0100;
  localparam logic [31:0] PC_B    = 32'h0000_0200;
  localparam logic [31:0] PC_C    = 32'h0000_0300;
  localparam int          INIT_CYCLES = 1024;
  localparam int          INIT_LIMIT  = 1100;

  logic clk = 1'b0;
  logic rst;

  tournament_pred_if bus();

  tournament_pred dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        br;
    logic        exp_take;
    logic        exp_src;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken);
    bus.pcM          = pc;
    bus.branchM      = 1'b1;
    bus.actual_takeM = taken;
    tick();
    bus.branchM      = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, output logic pred, output logic src);
    bus.pcF     = pc;
    bus.branchD = 1'b1;
    bus.flushD  = 1'b0;
    bus.stallD  = 1'b0;
    tick();
    pred = bus.pred_takeD;
    src  = bus.pred_srcD;
  endtask

  // Counts edges until init_done rises (bounded), noting any prediction leaking out.
  task automatic wait_init(output int cycles, output int leaks);
    cycles = 0;
    leaks  = 0;
    while (cycles < INIT_LIMIT) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.pred_takeD !== 1'b0) leaks++;
      if (bus.init_done === 1'b1) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cycles;
    int   leaks;
    logic pred;
    logic src;
    int   mis_total;
    int   mis_late;
    logic r;

    // stallD held, flushD clears, flush+stall clears, branchD gates the output.
    vecs[0]  = '{PC_Y, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{PC_X, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{PC_X, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{PC_X, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{PC_X, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{PC_X, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{PC_Y, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{PC_Y, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{PC_X, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{PC_Y, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{PC_Y, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{PC_Y, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst              = 1'b1;
    bus.flushD       = 1'b0;
    bus.stallD       = 1'b0;
    bus.pcF          = PC_Y;
    bus.pcM          = 32'h0;
    bus.branchM      = 1'b0;
    bus.actual_takeM = 1'b0;
    bus.branchD      = 1'b1;

    // Reset state
    #12;
    check("reset_pred_take", bus.pred_takeD, 1'b0);
    check("reset_pred_src",  bus.pred_srcD,  1'b0);
    check("reset_init_done", bus.init_done,  1'b0);
    #11;
    rst = 1'b0;

    // Init sweep length, predictions suppressed throughout
    wait_init(cycles, leaks);
    check("init_cycles", cycles, INIT_CYCLES);
    check("init_pred_leak", leaks, 0);
    lookup(PC_Y, pred, src);
    check("first_lookup_take", pred, 1'b1);
    check("first_lookup_src",  src,  1'b0);

    // X not taken once: local entry WT -> WNT, its history stays all-zero
    train(PC_X, 1'b0);

    // D-register control vectors
    for (int i = 0; i < 12; i++) begin
      bus.pcF     = vecs[i].pc;
      bus.flushD  = vecs[i].flush;
      bus.stallD  = vecs[i].stall;
      bus.branchD = vecs[i].br;
      tick();
      check($sformatf("vec%0d_take", i), bus.pred_takeD, vecs[i].exp_take);
      check($sformatf("vec%0d_src", i),  bus.pred_srcD,  vecs[i].exp_src);
    end
    bus.flushD  = 1'b0;
    bus.stallD  = 1'b0;
    bus.branchD = 1'b1;

    // Read-during-write: F and M hit X's WNT local entry in the same cycle
    bus.pcF          = PC_X;
    bus.pcM          = PC_X;
    bus.branchM      = 1'b1;
    bus.actual_takeM = 1'b1;
    tick();
    bus.branchM = 1'b0;
    check("rdw_same_cycle", bus.pred_takeD, 1'b0);
    tick();
    check("rdw_next_cycle", bus.pred_takeD, 1'b1);

    // Loop branch TTTTTTN x20: only the very first exit mispredicts
    mis_total = 0;
    mis_late  = 0;
    src       = 1'b0;
    for (int j = 0; j < 20; j++) begin
      for (int k = 0; k < 7; k++) begin
        lookup(PC_LOOP, pred, src);
        if (pred !== (k != 6)) begin
          mis_total++;
          if (j >= 4) mis_late++;
        end
        train(PC_LOOP, k != 6);
      end
    end
    check("loop_mispredicts_late",  mis_late,  0);
    check("loop_mispredicts_total", mis_total, 1);
    check("loop_src_local",         src,       1'b0);

    // B copies A's random outcome; a fixed always-taken C branch pins the older history
    mis_late = 0;
    for (int p = 0; p < 80; p++) begin
      r = 1'($urandom_range(1, 0));
      repeat (7) train(PC_C, 1'b1);
      train(PC_A, r);
      lookup(PC_B, pred, src);
      if (p >= 50 && pred !== r) mis_late++;
      train(PC_B, r);
    end
    check("corr_mispredicts_late", mis_late, 0);
    check("corr_src_global",       src,      1'b1);

    // Mid-run reset between edges
    lookup(PC_Y, pred, src);
    check("pre_reset_take", pred, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pred_take", bus.pred_takeD, 1'b0);
    check("midrst_init_done", bus.init_done,  1'b0);
    #2;
    rst = 1'b0;
    wait_init(cycles, leaks);
    check("reinit_cycles", cycles, INIT_CYCLES);
    check("reinit_pred_leak", leaks, 0);
    lookup(PC_B, pred, src);
    check("reinit_b_take", pred, 1'b1);
    check("reinit_b_src",  src,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
